// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: ARB -> ACCESS -> RESP pipeline.
// Define DMEM_ARB_RR_EN for round-robin tie-break; default build uses fixed priority (requester 0).
module dmem_arbiter #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  logic        lg_q, lg_d;
  logic        acc_valid_q, acc_valid_d;
  logic        acc_owner_q, acc_owner_d;
  logic        acc_we_q, acc_we_d;
  logic        acc_err_q, acc_err_d;
  logic [31:0] acc_a_q, acc_a_d;
  logic [31:0] acc_wd_q, acc_wd_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata_q, rdata_d;

  logic        grant;
  logic [31:0] sel_a;

  // Grants are gated by reset so nothing is accepted while rst_n is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
        gnt0 = lg_q;
        gnt1 = ~lg_q;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign grant = gnt0 | gnt1;
  assign sel_a = gnt1 ? a1 : a0;

  always_comb begin
    lg_d        = lg_q;
    acc_valid_d = grant;
    acc_owner_d = acc_owner_q;
    acc_we_d    = acc_we_q;
    acc_err_d   = acc_err_q;
    acc_a_d     = acc_a_q;
    acc_wd_d    = acc_wd_q;
    if (grant) begin
      lg_d        = gnt1;
      acc_owner_d = gnt1;
      acc_we_d    = gnt1 ? we1 : we0;
      acc_a_d     = sel_a;
      acc_wd_d    = gnt1 ? wd1 : wd0;
      acc_err_d   = (sel_a[1:0] != 2'b00) || (sel_a >= ADDR_LIMIT);
    end
  end

  // Response stage: read data is only returned for clean reads, zero otherwise.
  always_comb begin
    ack0_d  = acc_valid_q & ~acc_owner_q;
    ack1_d  = acc_valid_q & acc_owner_q;
    err0_d  = acc_valid_q & ~acc_owner_q & acc_err_q;
    err1_d  = acc_valid_q & acc_owner_q & acc_err_q;
    rdata_d = 32'h0;
    if (acc_valid_q && !acc_we_q && !acc_err_q) begin
      rdata_d = mem_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg_q        <= 1'b1;
      acc_valid_q <= 1'b0;
      acc_owner_q <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_err_q   <= 1'b0;
      acc_a_q     <= 32'h0;
      acc_wd_q    <= 32'h0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      lg_q        <= lg_d;
      acc_valid_q <= acc_valid_d;
      acc_owner_q <= acc_owner_d;
      acc_we_q    <= acc_we_d;
      acc_err_q   <= acc_err_d;
      acc_a_q     <= acc_a_d;
      acc_wd_q    <= acc_wd_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_we = acc_valid_q & acc_we_q & ~acc_err_q;
  assign mem_a  = acc_a_q;
  assign mem_wd = acc_wd_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dmem model.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req0, req1, we0, we1;
  logic [31:0] a0, a1, wd0, wd1;
  logic        gnt0, gnt1, ack0, ack1, err0, err1;
  logic [31:0] rdata, memA, memWd, memRd;
  logic        memWe;

  logic [31:0] mem [128];
  logic        memLoaded = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_WORDS(128)) dut (
    .clk(clk), .rst_n(rstN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_we(memWe), .mem_a(memA), .mem_wd(memWd), .mem_rd(memRd)
  );

  // Memory model: preloaded with a recognisable pattern, word 8 starts at zero.
  assign memRd = mem[memA[8:2]];
  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= {16'hC0DE, 16'(i)};
      mem[8]    <= 32'h0;
      memLoaded <= 1'b1;
    end else if (memWe) begin
      mem[memA[8:2]] <= memWd;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] ad0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [31:0] ad1, input logic [31:0] d1);
    req0 = r0; we0 = w0; a0 = ad0; wd0 = d0;
    req1 = r1; we1 = w1; a1 = ad1; wd1 = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic expG1;

  initial begin
    rstN = 1'b0;
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstGnt0", 32'(gnt0), 32'd0);
    checkOutput("rstGnt1", 32'(gnt1), 32'd0);
    checkOutput("rstAck", {30'd0, ack1, ack0}, 32'd0);
    checkOutput("rstErr", {30'd0, err1, err0}, 32'd0);
    checkOutput("rstRdata", rdata, 32'h0);
    checkOutput("rstMemWe", 32'(memWe), 32'd0);
    checkOutput("rstMemA", memA, 32'h0);
    checkOutput("rstMemWd", memWd, 32'h0);

    // First cycle after reset release: the held read of address 0 is granted.
    step();
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("relGnt0", 32'(gnt0), 32'd1);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("relAckEarly", 32'(ack0), 32'd0);
    checkOutput("relMemWe", 32'(memWe), 32'd0);
    step();
    @(negedge clk);
    checkOutput("relAck0", 32'(ack0), 32'd1);
    checkOutput("relRdata", rdata, 32'hC0DE0000);

    // Write 0x10 then read it back the following cycle.
    step();
    applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("wrGnt0", 32'(gnt0), 32'd1);
    step();
    applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rdGnt0", 32'(gnt0), 32'd1);
    checkOutput("wrMemWe", 32'(memWe), 32'd1);
    checkOutput("wrMemA", memA, 32'h10);
    checkOutput("wrMemWd", memWd, 32'hDEADBEEF);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("wrAck0", 32'(ack0), 32'd1);
    checkOutput("wrRdataZero", rdata, 32'h0);
    checkOutput("rdMemWe", 32'(memWe), 32'd0);
    step();
    @(negedge clk);
    checkOutput("rdAck0", 32'(ack0), 32'd1);
    checkOutput("rdRdata", rdata, 32'hDEADBEEF);
    checkOutput("rdErr0", 32'(err0), 32'd0);
    step();
    @(negedge clk);
    checkOutput("rdAckDone", 32'(ack0), 32'd0);

    // Requester 1: misaligned write, then out-of-range read.
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h13, 32'h12345678);
    @(negedge clk);
    checkOutput("errWrGnt1", 32'(gnt1), 32'd1);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h200, 32'h0);
    @(negedge clk);
    checkOutput("errWrMemWe", 32'(memWe), 32'd0);
    checkOutput("errRdGnt1", 32'(gnt1), 32'd1);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("errWrAckErr1", {30'd0, ack1, err1}, 32'd3);
    checkOutput("errWrAck0", 32'(ack0), 32'd0);
    checkOutput("errWrRdata", rdata, 32'h0);
    checkOutput("errRdMemWe", 32'(memWe), 32'd0);
    step();
    @(negedge clk);
    checkOutput("errRdAckErr1", {30'd0, ack1, err1}, 32'd3);
    checkOutput("errRdRdata", rdata, 32'h0);
    step();
    @(negedge clk);
    checkOutput("errDone", {30'd0, ack1, err1}, 32'd0);

    // Contention: last grant went to requester 1, so requester 0 wins the first tie.
    step();
    applyStimulus(1, 0, 32'h4, 32'h0, 1, 0, 32'h8, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      @(negedge clk);
`ifdef DMEM_ARB_RR_EN
      expG1 = (k % 2) == 1;
`else
      expG1 = 1'b0;
`endif
      checkOutput($sformatf("tieGnt0_%0d", k), 32'(gnt0), 32'(!expG1));
      checkOutput($sformatf("tieGnt1_%0d", k), 32'(gnt1), 32'(expG1));
    end
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
    @(negedge clk);
    checkOutput("soloGnt1", 32'(gnt1), 32'd1);
    checkOutput("soloGnt0", 32'(gnt0), 32'd0);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    step();

    // Reset arrives in the response cycle of a write that has already committed.
    applyStimulus(1, 1, 32'h20, 32'h5A5A1234, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("midGnt0", 32'(gnt0), 32'd1);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("midMemWe", 32'(memWe), 32'd1);
    checkOutput("midMemA", memA, 32'h20);
    step();
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midAckDropped", 32'(ack0), 32'd0);
    step();
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("midAckAfter", 32'(ack0), 32'd0);
    step();
    applyStimulus(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("midRdGnt0", 32'(gnt0), 32'd1);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    step();
    @(negedge clk);
    checkOutput("midRdAck0", 32'(ack0), 32'd1);
    checkOutput("midRdData", rdata, 32'h5A5A1234);

    // Alternating owners back to back.
    step();
    applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("altGnt0", 32'(gnt0), 32'd1);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
    @(negedge clk);
    checkOutput("altGnt1", 32'(gnt1), 32'd1);
    step();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("altAcks0", {30'd0, ack1, ack0}, 32'd1);
    checkOutput("altRdata0", rdata, 32'hC0DE0000);
    step();
    @(negedge clk);
    checkOutput("altAcks1", {30'd0, ack1, ack0}, 32'd2);
    checkOutput("altRdata1", rdata, 32'hC0DE0001);
    step();
    @(negedge clk);
    checkOutput("altIdle", {30'd0, ack1, ack0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
